uart_mode2_rx_ctrl: RTL and testbench
=====================================

Name: uart_mode2_rx_ctrl

Overview:
Receive-side controller for the 8051-style UART Mode 2 receiver core. It gates the serial line with REN and supervises each frame with a timeout, aborting the core on error. It applies SM2 multiprocessor address filtering, owns SBUF/RB8/RI with a one-deep hold buffer, and flags overrun. It sits between the pin and CPU SFR logic on one side and the bit-level receiver core on the other.

Parameters:
CLK_PER_BIT, 100, clk cycles per serial bit; must match the receiver core.
TIMEOUT_BITS, 12, frame watchdog length in bit times; timeout = TIMEOUT_BITS*CLK_PER_BIT cycles.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
ren  in  1  receive enable (SCON.REN)
sm2  in  1  multiprocessor mode (SCON.SM2)
ri_clr  in  1  CPU clears RI (1-cycle pulse)
ovr_clr  in  1  CPU clears overrun flag
rxd_pin  in  1  serial line from pad
rxd_core  out  1  gated line to receiver core
core_rst  out  1  synchronous abort pulse to receiver core
core_data  in  8  receiver core data_out
core_rb8  in  1  receiver core 9th bit
core_done  in  1  receiver core frame-complete pulse
sbuf  out  8  received byte visible to CPU
rb8  out  1  9th bit of sbuf frame
ri  out  1  receive interrupt flag
hold_valid  out  1  hold buffer occupied
ovr  out  1  sticky overrun flag
busy  out  1  frame in progress or abort in progress

Behaviour:
- Reset: state=OFF; sbuf=0, rb8=0, ri=0, hold_valid=0, ovr=0, core_rst=0, busy=0; hold regs=0; edge register prev=1; timer=0.
- rxd_core = rxd_pin when state != OFF, else constant 1 (combinational). prev registers rxd_core every cycle.
- States: OFF, IDLE, BUSY, FLUSH.
  - OFF: ren=1 -> IDLE.
  - IDLE: ren=0 -> OFF. prev=1 and rxd_core=0 (falling edge) -> BUSY, timer<=0.
  - BUSY: timer increments each cycle.
    - core_done=1 -> accept logic, -> IDLE. core_done has priority over timeout and ren=0 in the same cycle.
    - Else ren=0 or timer==TIMEOUT_BITS*CLK_PER_BIT-1 -> FLUSH; frame discarded.
  - FLUSH: exactly one cycle; core_rst=1 (registered, high only in this cycle) -> IDLE if ren=1, else OFF.
- busy=1 in BUSY and FLUSH.
- core_done outside BUSY is ignored.
- Accept rule, on core_done in BUSY; all decisions use pre-edge ri and hold_valid:
  - Frame qualifies if sm2=0 or core_rb8=1; a non-qualifying frame is dropped silently (no flag).
  - Qualified, ri=0 and hold_valid=0: sbuf<=core_data, rb8<=core_rb8, ri<=1.
  - Qualified, ri=1, hold_valid=0: hold<=frame, hold_valid<=1.
  - Qualified, hold_valid=1, with the hold-transfer condition also true this cycle: sbuf<=hold, hold<=new frame, hold_valid stays 1, ri<=1.
  - Qualified, hold_valid=1 otherwise: ovr<=1; frame dropped; sbuf and hold unchanged.
- ri_clr with ri=1 sets ri<=0. An accept setting ri in the same cycle as ri_clr is impossible, since the accept rule uses pre-edge ri.
- Hold transfer: in any cycle with ri=0 and hold_valid=1, sbuf<=hold, rb8<=hold_rb8, ri<=1, hold_valid<=0 unless refilled. After ri_clr with a full hold, ri is low for exactly one cycle, then high with the held byte.
- ovr: set wins over simultaneous ovr_clr; cleared only by ovr_clr or rst.
- ren=0 never clears sbuf, rb8, ri, hold or ovr.
- Timer width: clog2(TIMEOUT_BITS*CLK_PER_BIT) bits; no wrap, because the FLUSH exit occurs first.

Test Plan:
- CLK_PER_BIT=4, ren=1, sm2=0, frame 0x5A rb8=0 -> busy high from start edge; on core_done: sbuf=0x5A, rb8=0, ri=1 next cycle; busy=0.
- sm2=1, frame 0x33 rb8=0 -> ri stays 0, sbuf unchanged. Then frame 0x81 rb8=1 -> sbuf=0x81, rb8=1, ri=1.
- ri=1 and three qualified frames A1, A2, A3 without ri_clr -> A1 in sbuf, A2 in hold, hold_valid=1, ovr=1 after A3. Then ri_clr -> ri=0 for one cycle, then sbuf=A2, ri=1, hold_valid=0.
- Start edge then line held low with no core_done -> after 48 cycles in BUSY: FLUSH, core_rst high exactly one cycle, state IDLE, ri unchanged.
- ren dropped mid-frame -> FLUSH next cycle, core_rst pulse, then OFF. rxd_core=1 while OFF; a toggling rxd_pin never sets busy.
- Async rst asserted mid-frame with ri=1 and ovr=1 -> all outputs 0 immediately; rxd_core=1 until ren is seen after reset release.

Source files
------------

// File: rtl/uart_mode2_rx_ctrl.sv
// Receive-side controller for the 8051-style UART Mode 2 receiver core:
// line gating, frame watchdog, SM2 address filtering, SBUF/RB8/RI ownership with a one-deep hold buffer.
module uart_mode2_rx_ctrl #(
  parameter int unsigned CLK_PER_BIT  = 100,
  parameter int unsigned TIMEOUT_BITS = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ren,
  input  logic       sm2,
  input  logic       ri_clr,
  input  logic       ovr_clr,
  input  logic       rxd_pin,
  output logic       rxd_core,
  output logic       core_rst,
  input  logic [7:0] core_data,
  input  logic       core_rb8,
  input  logic       core_done,
  output logic [7:0] sbuf,
  output logic       rb8,
  output logic       ri,
  output logic       hold_valid,
  output logic       ovr,
  output logic       busy
);

  localparam int unsigned TIMEOUT_CYC = TIMEOUT_BITS * CLK_PER_BIT;
  localparam int unsigned TIMER_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_BUSY  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic               prev;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic [7:0]         sbuf_nxt;
  logic               rb8_nxt, ri_nxt;
  logic [7:0]         hold_data, hold_data_nxt;
  logic               hold_rb8, hold_rb8_nxt;
  logic               hold_valid_nxt, ovr_nxt;
  logic               core_rst_nxt, busy_nxt;
  logic               fall_edge, accept, xfer, ovr_set;

  // Line is held idle-high toward the core while the receiver is disabled
  assign rxd_core  = (state != ST_OFF) ? rxd_pin : 1'b1;
  assign fall_edge = prev && !rxd_core;

  // Next-state, watchdog and buffer-ownership logic
  always_comb begin
    state_nxt      = state;
    timer_nxt      = timer;
    sbuf_nxt       = sbuf;
    rb8_nxt        = rb8;
    ri_nxt         = ri;
    hold_data_nxt  = hold_data;
    hold_rb8_nxt   = hold_rb8;
    hold_valid_nxt = hold_valid;
    ovr_nxt        = ovr;
    accept         = 1'b0;
    ovr_set        = 1'b0;
    xfer           = !ri && hold_valid;

    unique case (state)
      ST_OFF: begin
        if (ren) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (!ren) begin
          state_nxt = ST_OFF;
        end else if (fall_edge) begin
          state_nxt = ST_BUSY;
          timer_nxt = '0;
        end
      end
      ST_BUSY: begin
        timer_nxt = timer + TIMER_W'(1);
        if (core_done) begin
          accept    = !sm2 || core_rb8;
          state_nxt = ST_IDLE;
        end else if (!ren || timer == TIMER_LAST) begin
          state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        state_nxt = ren ? ST_IDLE : ST_OFF;
      end
      default: state_nxt = ST_OFF;
    endcase

    if (ri_clr && ri) ri_nxt = 1'b0;

    // Hold buffer drains into SBUF as soon as RI is low
    if (xfer) begin
      sbuf_nxt       = hold_data;
      rb8_nxt        = hold_rb8;
      ri_nxt         = 1'b1;
      hold_valid_nxt = 1'b0;
    end

    // Placement decisions use pre-edge ri / hold_valid
    if (accept) begin
      if (!ri && !hold_valid) begin
        sbuf_nxt = core_data;
        rb8_nxt  = core_rb8;
        ri_nxt   = 1'b1;
      end else if (!hold_valid || xfer) begin
        hold_data_nxt  = core_data;
        hold_rb8_nxt   = core_rb8;
        hold_valid_nxt = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end

    if (ovr_clr) ovr_nxt = 1'b0;
    if (ovr_set) ovr_nxt = 1'b1;

    core_rst_nxt = (state_nxt == ST_FLUSH);
    busy_nxt     = (state_nxt == ST_BUSY) || (state_nxt == ST_FLUSH);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_OFF;
      prev       <= 1'b1;
      timer      <= '0;
      sbuf       <= '0;
      rb8        <= 1'b0;
      ri         <= 1'b0;
      hold_data  <= '0;
      hold_rb8   <= 1'b0;
      hold_valid <= 1'b0;
      ovr        <= 1'b0;
      core_rst   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      prev       <= rxd_core;
      timer      <= timer_nxt;
      sbuf       <= sbuf_nxt;
      rb8        <= rb8_nxt;
      ri         <= ri_nxt;
      hold_data  <= hold_data_nxt;
      hold_rb8   <= hold_rb8_nxt;
      hold_valid <= hold_valid_nxt;
      ovr        <= ovr_nxt;
      core_rst   <= core_rst_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_uart_mode2_rx_ctrl.sv
// Self-checking bench for uart_mode2_rx_ctrl; the bench plays the receiver core.
module tb_uart_mode2_rx_ctrl;

  localparam int unsigned CLK_PER_BIT  = 4;
  localparam int unsigned TIMEOUT_BITS = 12;
  localparam int unsigned TIMEOUT_CYC  = CLK_PER_BIT * TIMEOUT_BITS;

  logic       clk = 1'b0;
  logic       rst;
  logic       ren, sm2, ri_clr, ovr_clr, rxd_pin;
  logic       rxd_core, core_rst;
  logic [7:0] core_data;
  logic       core_rb8, core_done;
  logic [7:0] sbuf;
  logic       rb8, ri, hold_valid, ovr, busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] exp_q[$];
  logic       ri_q = 1'b0;

  uart_mode2_rx_ctrl #(
    .CLK_PER_BIT (CLK_PER_BIT),
    .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ren       (ren),
    .sm2       (sm2),
    .ri_clr    (ri_clr),
    .ovr_clr   (ovr_clr),
    .rxd_pin   (rxd_pin),
    .rxd_core  (rxd_core),
    .core_rst  (core_rst),
    .core_data (core_data),
    .core_rb8  (core_rb8),
    .core_done (core_done),
    .sbuf      (sbuf),
    .rb8       (rb8),
    .ri        (ri),
    .hold_valid(hold_valid),
    .ovr       (ovr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every rising edge of ri must present the next queued {rb8, sbuf}
  always @(negedge clk) begin
    if (ri && !ri_q) begin
      check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("sb_sbuf", 32'(sbuf), 32'(e[7:0]));
        check("sb_rb8", 32'(rb8), 32'(e[8]));
      end
    end
    ri_q = ri;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic b);
    rxd_pin = 1'b0;
    tick();
    check("busy_start", 32'(busy), 32'd1);
    repeat (3) tick();
    core_data = d;
    core_rb8  = b;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    rxd_pin   = 1'b1;
    check("busy_end", 32'(busy), 32'd0);
    tick();
  endtask

  task automatic pulse_ri_clr();
    ri_clr = 1'b1;
    tick();
    ri_clr = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; ren = 1'b0; sm2 = 1'b0; ri_clr = 1'b0; ovr_clr = 1'b0;
    rxd_pin = 1'b1; core_data = '0; core_rb8 = 1'b0; core_done = 1'b0;
    #12;
    check("rst_sbuf", 32'(sbuf), 32'd0);
    check("rst_ri", 32'(ri), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rxd_core", 32'(rxd_core), 32'd1);
    rst = 1'b0;
    tick();
    ren = 1'b1;
    tick();
    tick();

    // Basic frame
    exp_q.push_back({1'b0, 8'h5A});
    send_frame(8'h5A, 1'b0);
    check("f1_ri", 32'(ri), 32'd1);

    // core_done outside BUSY is ignored
    pulse_ri_clr();
    core_data = 8'hEE; core_rb8 = 1'b1; core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
    check("idle_done_ri", 32'(ri), 32'd0);
    check("idle_done_sbuf", 32'(sbuf), 32'h5A);

    // SM2 filtering
    sm2 = 1'b1;
    send_frame(8'h33, 1'b0);
    check("sm2_drop_ri", 32'(ri), 32'd0);
    check("sm2_drop_sbuf", 32'(sbuf), 32'h5A);
    exp_q.push_back({1'b1, 8'h81});
    send_frame(8'h81, 1'b1);
    check("sm2_addr_ri", 32'(ri), 32'd1);

    // Hold buffer and overrun
    pulse_ri_clr();
    sm2 = 1'b0;
    tick();
    exp_q.push_back({1'b0, 8'hA1});
    send_frame(8'hA1, 1'b0);
    exp_q.push_back({1'b1, 8'hA2});
    send_frame(8'hA2, 1'b1);
    check("hold_valid_a2", 32'(hold_valid), 32'd1);
    check("ovr_before_a3", 32'(ovr), 32'd0);
    send_frame(8'hA3, 1'b0);
    check("ovr_a3", 32'(ovr), 32'd1);
    check("sbuf_a1", 32'(sbuf), 32'hA1);
    check("hold_valid_a3", 32'(hold_valid), 32'd1);
    pulse_ri_clr();
    check("xfer_ri_low", 32'(ri), 32'd0);
    check("xfer_hold_still", 32'(hold_valid), 32'd1);
    tick();
    check("xfer_ri_high", 32'(ri), 32'd1);
    check("xfer_hold_empty", 32'(hold_valid), 32'd0);
    check("xfer_sbuf", 32'(sbuf), 32'hA2);

    // Frame watchdog
    rxd_pin = 1'b0;
    tick();
    check("to_busy", 32'(busy), 32'd1);
    n = 0;
    while (!core_rst && n < 200) begin
      tick();
      n++;
    end
    check("to_cycles", 32'(n), 32'(TIMEOUT_CYC));
    check("to_flush_busy", 32'(busy), 32'd1);
    tick();
    check("to_core_rst_off", 32'(core_rst), 32'd0);
    check("to_idle_busy", 32'(busy), 32'd0);
    check("to_ri_kept", 32'(ri), 32'd1);
    check("to_sbuf_kept", 32'(sbuf), 32'hA2);
    rxd_pin = 1'b1;
    tick();

    // ren dropped mid-frame
    rxd_pin = 1'b0;
    tick();
    check("ren_busy", 32'(busy), 32'd1);
    tick();
    ren = 1'b0;
    tick();
    check("ren_core_rst", 32'(core_rst), 32'd1);
    tick();
    check("ren_core_rst_off", 32'(core_rst), 32'd0);
    check("ren_busy_off", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) begin
      rxd_pin = ~rxd_pin;
      tick();
      check("off_rxd_core", 32'(rxd_core), 32'd1);
      check("off_busy", 32'(busy), 32'd0);
    end
    check("off_ri_kept", 32'(ri), 32'd1);
    check("off_ovr_kept", 32'(ovr), 32'd1);

    // Async reset mid-frame
    rxd_pin = 1'b1;
    ren = 1'b1;
    tick();
    tick();
    rxd_pin = 1'b0;
    tick();
    check("ar_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_ri", 32'(ri), 32'd0);
    check("ar_ovr", 32'(ovr), 32'd0);
    check("ar_sbuf", 32'(sbuf), 32'd0);
    check("ar_rb8", 32'(rb8), 32'd0);
    check("ar_hold_valid", 32'(hold_valid), 32'd0);
    check("ar_busy_off", 32'(busy), 32'd0);
    check("ar_core_rst", 32'(core_rst), 32'd0);
    check("ar_rxd_core", 32'(rxd_core), 32'd1);
    tick();
    rst = 1'b0;
    #1;
    check("ar_rel_rxd_core", 32'(rxd_core), 32'd1);
    tick();
    check("ar_ren_rxd_core", 32'(rxd_core), 32'd0);
    tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench watchdog expired");
  end

endmodule
